// File: rtl/prio_enc4_sync_pkg.sv
// Shared types, widths and helpers for the buffered 4-line priority encoder.
package prio_enc4_sync_pkg;

  // Width of the encoded line index.
  localparam int CODE_W = 2;

  // Width of the saturating "no line asserted" sample counter.
  localparam int CNT_W = 8;

  // Pointer width covers the largest supported buffer depth of four.
  localparam int PTR_W = 2;

  // Occupancy width holds counts 0..4.
  localparam int OCC_W = 3;

  // Occupancy of the output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PART  = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // One buffered result: encoded index plus the multi-line flag.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              multi;
  } entry_t;

  // Advance a buffer pointer, wrapping back to zero after the last entry.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr,
                                               input int depth);
    logic [PTR_W-1:0] lastIdx;
    lastIdx = PTR_W'(depth - 1);
    if (ptr == lastIdx) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  // Number of asserted lines among the four inputs.
  function automatic logic [2:0] countOnes4(input logic a, input logic b,
                                            input logic c, input logic d);
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

endpackage

// File: rtl/prio_enc4_core.sv
// Purely combinational 4-to-2 priority encoder with selectable priority order.
module prio_enc4_core
  import prio_enc4_sync_pkg::*;
(
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic hi_first,
  output logic c0,
  output logic c1,
  output logic any,
  output logic multi
);

  logic [CODE_W-1:0] code;
  logic [2:0]        onesCount;

  // Pick the index of the winning line; i3 wins when hi_first, i0 wins otherwise.
  always_comb begin
    code      = '0;
    onesCount = countOnes4(i0, i1, i2, i3);
    any       = (onesCount != 3'd0);
    multi     = (onesCount >= 3'd2);
    if (hi_first) begin
      if (i3) begin
        code = 2'd3;
      end else if (i2) begin
        code = 2'd2;
      end else if (i1) begin
        code = 2'd1;
      end else begin
        code = 2'd0;
      end
    end else begin
      if (i0) begin
        code = 2'd0;
      end else if (i1) begin
        code = 2'd1;
      end else if (i2) begin
        code = 2'd2;
      end else if (i3) begin
        code = 2'd3;
      end else begin
        code = 2'd0;
      end
    end
    c1 = code[1];
    c0 = code[0];
  end

endmodule

// File: rtl/prio_enc4_sync.sv
// Priority encoder whose results are queued in a small FIFO with ready/valid
// handshakes on both sides; samples with no line asserted are only counted.
module prio_enc4_sync
  import prio_enc4_sync_pkg::*;
#(
  parameter int DEPTH    = 2,   // buffer entries, 1..4
  parameter int HI_FIRST = 1    // 1: i3 highest priority, 0: i0 highest
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0,
  input  logic             i1,
  input  logic             i2,
  input  logic             i3,
  input  logic             en,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic             c0,
  output logic             c1,
  output logic             multi,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] none_cnt
);

  // Encoder results for the current input lines.
  logic encC0;
  logic encC1;
  logic encAny;
  logic encMulti;

  // Buffer storage is always four deep so a 2-bit pointer indexes it cleanly;
  // only the first DEPTH entries are ever used.
  entry_t entry_q [4];
  entry_t headEntry;

  occ_state_e       state_q;
  occ_state_e       state_d;
  logic [OCC_W-1:0] count_q;
  logic [OCC_W-1:0] count_d;
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] rdPtr_d;
  logic [CNT_W-1:0] noneCnt_q;
  logic [CNT_W-1:0] noneCnt_d;

  logic accept;
  logic push;
  logic pop;
  logic isFull;

  prio_enc4_core u_core (
    .i0       (i0),
    .i1       (i1),
    .i2       (i2),
    .i3       (i3),
    .hi_first (HI_FIRST != 0),
    .c0       (encC0),
    .c1       (encC1),
    .any      (encAny),
    .multi    (encMulti)
  );

  // Handshake decode; a full buffer refuses input even when it is popping.
  always_comb begin
    isFull  = (state_q == FULL);
    out_vld = (state_q != EMPTY);
    in_rdy  = en & ~isFull & ~rst;
    accept  = in_vld & in_rdy;
    push    = accept & encAny;
    pop     = out_vld & out_rdy;
  end

  // Next occupancy state, count, pointers and empty-sample counter.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    noneCnt_d = noneCnt_q;

    if (push) begin
      wrPtr_d = nextPtr(wrPtr_q, DEPTH);
    end
    if (pop) begin
      rdPtr_d = nextPtr(rdPtr_q, DEPTH);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = (DEPTH == 1) ? FULL : PART;
        end
      end
      PART: begin
        if (push && !pop && (count_q == OCC_W'(DEPTH - 1))) begin
          state_d = FULL;
        end else if (pop && !push && (count_q == OCC_W'(1))) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop && !push) begin
          state_d = (DEPTH == 1) ? EMPTY : PART;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (accept && !encAny && (noneCnt_q != {CNT_W{1'b1}})) begin
      noneCnt_d = noneCnt_q + CNT_W'(1);
    end
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      count_q   <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      noneCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      noneCnt_q <= noneCnt_d;
    end
  end

  // Buffer storage; a new result lands at the tail on every push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        entry_q[k] <= '0;
      end
    end else if (push) begin
      entry_q[wrPtr_q] <= '{code: {encC1, encC0}, multi: encMulti};
    end
  end

  // Head of the buffer drives the outputs, forced to zero while empty.
  always_comb begin
    headEntry = entry_q[rdPtr_q];
    c1        = out_vld & headEntry.code[1];
    c0        = out_vld & headEntry.code[0];
    multi     = out_vld & headEntry.multi;
    none_cnt  = noneCnt_q;
  end

endmodule
